// File: rtl/path_replayer.sv
// path_replayer: rebuilds a solved maze path from the direction deque and streams (X,Y) beats.
// Optional pop counter output Steps is enabled by defining PATH_STEP_COUNT_EN.
module path_replayer #(
    parameter int unsigned W       = 4,
    parameter int unsigned START_X = 0,
    parameter int unsigned START_Y = 0,
    parameter int unsigned GOAL_X  = 15,
    parameter int unsigned GOAL_Y  = 15
`ifdef PATH_STEP_COUNT_EN
    ,
    parameter int unsigned STEP_W  = 8
`endif
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              deque_empty,
    input  logic [1:0]        deque_dir,
    output logic              pop_front,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      X,
    output logic [W-1:0]      Y,
    output logic [1:0]        Dir_out,
    output logic              Busy,
    output logic              Done,
`ifdef PATH_STEP_COUNT_EN
    output logic [STEP_W-1:0] Steps,
`endif
    output logic              Error
);

    localparam logic [W-1:0] SX   = W'(START_X);
    localparam logic [W-1:0] SY   = W'(START_Y);
    localparam logic [W-1:0] GX   = W'(GOAL_X);
    localparam logic [W-1:0] GY   = W'(GOAL_Y);
    localparam logic [W-1:0] CMAX = '1;
    localparam logic [W-1:0] ONE  = W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SHOW, S_FETCH, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]   dir_q, dir_d;
    logic         oob;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        pop_front = 1'b0;
        out_valid = 1'b0;
        oob       = 1'b0;
        case (state_q)
            S_IDLE: if (Start) state_d = S_INIT;
            S_INIT: begin
                x_d     = SX;
                y_d     = SY;
                dir_d   = 2'b00;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                out_valid = 1'b1;
                if (out_ready) state_d = deque_empty ? S_CHECK : S_FETCH;
            end
            S_FETCH: begin
                // Entry is popped even when the step is rejected; X/Y keep the last legal cell.
                if (deque_empty) begin
                    state_d = S_CHECK;
                end else begin
                    pop_front = 1'b1;
                    case (deque_dir)
                        2'b00:   oob = (y_q == CMAX);
                        2'b01:   oob = (x_q == CMAX);
                        2'b10:   oob = (x_q == '0);
                        default: oob = (y_q == '0);
                    endcase
                    if (oob) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_SHOW;
                        dir_d   = deque_dir;
                        case (deque_dir)
                            2'b00:   y_d = y_q + ONE;
                            2'b01:   x_d = x_q + ONE;
                            2'b10:   x_d = x_q - ONE;
                            default: y_d = y_q - ONE;
                        endcase
                    end
                end
            end
            S_CHECK: state_d = (x_q == GX && y_q == GY) ? S_DONE : S_ERROR;
            S_DONE:  if (Start) state_d = S_INIT;
            S_ERROR: if (Start) state_d = S_INIT;
            default: state_d = S_IDLE;
        endcase
    end

    assign X       = x_q;
    assign Y       = y_q;
    assign Dir_out = dir_q;
    assign Busy    = (state_q == S_INIT) || (state_q == S_SHOW) ||
                     (state_q == S_FETCH) || (state_q == S_CHECK);
    assign Done    = (state_q == S_DONE);
    assign Error   = (state_q == S_ERROR);

`ifdef PATH_STEP_COUNT_EN
    logic [STEP_W-1:0] steps_q, steps_d;

    always_comb begin
        steps_d = steps_q;
        if (state_q == S_INIT) steps_d = '0;
        else if (pop_front && steps_q != '1) steps_d = steps_q + STEP_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) steps_q <= '0;
        else        steps_q <= steps_d;
    end

    assign Steps = steps_q;
`endif

endmodule

// File: tb/tb_path_replayer.sv
// Bench for path_replayer: four instances with different goal cells share one deque model.
module tb_path_replayer;
    localparam int NI = 4;
    localparam int GX[NI] = '{0, 2, 15, 0};
    localparam int GY[NI] = '{0, 1, 15, 1};

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [NI-1:0] start_v;
    logic          deque_empty;
    logic [1:0]    deque_dir;
    logic          out_ready;

    logic          pop_o[NI];
    logic          valid_o[NI];
    logic          busy_o[NI];
    logic          done_o[NI];
    logic          err_o[NI];
    logic [3:0]    x_o[NI];
    logic [3:0]    y_o[NI];
    logic [1:0]    dir_o[NI];
`ifdef PATH_STEP_COUNT_EN
    logic [7:0]    steps_o[NI];
`endif

    logic [1:0] dq_mem[0:63];
    int dq_head, dq_tail, sel;

    assign deque_empty = (dq_head == dq_tail);
    assign deque_dir   = dq_mem[dq_head];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        path_replayer #(
            .W(4), .START_X(0), .START_Y(0), .GOAL_X(GX[g]), .GOAL_Y(GY[g])
        ) u_dut (
            .Clk(Clk), .Rst_n(Rst_n), .Start(start_v[g]),
            .deque_empty(deque_empty), .deque_dir(deque_dir),
            .pop_front(pop_o[g]), .out_valid(valid_o[g]), .out_ready(out_ready),
            .X(x_o[g]), .Y(y_o[g]), .Dir_out(dir_o[g]),
            .Busy(busy_o[g]), .Done(done_o[g]),
`ifdef PATH_STEP_COUNT_EN
            .Steps(steps_o[g]),
`endif
            .Error(err_o[g])
        );
    end

    always #5 Clk = ~Clk;

    int checks, errors;
    int exp_x[0:31], exp_y[0:31], exp_d[0:31];
    int exp_n, exp_pops, exp_fx, exp_fy;
    bit exp_done;
    int beat_i, pop_base;
    bit chk_en;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] d);
        dq_mem[dq_tail] = d;
        dq_tail++;
    endtask

    // Walks the pending deque entries with plain integer coordinates.
    task automatic build_model(input int idx);
        int cx, cy, nx, ny;
        bit bad;
        cx = 0; cy = 0; bad = 0;
        exp_n = 1; exp_pops = 0;
        exp_x[0] = 0; exp_y[0] = 0; exp_d[0] = 0;
        for (int k = dq_head; k < dq_tail && !bad; k++) begin
            exp_pops++;
            nx = cx; ny = cy;
            case (dq_mem[k])
                2'b00: ny = cy + 1;
                2'b01: nx = cx + 1;
                2'b10: nx = cx - 1;
                default: ny = cy - 1;
            endcase
            if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
                bad = 1;
            end else begin
                cx = nx; cy = ny;
                exp_x[exp_n] = cx; exp_y[exp_n] = cy; exp_d[exp_n] = int'(dq_mem[k]);
                exp_n++;
            end
        end
        exp_done = !bad && cx == GX[idx] && cy == GY[idx];
        exp_fx = cx; exp_fy = cy;
    endtask

    task automatic run_begin(input int idx);
        build_model(idx);
        sel = idx; beat_i = 0; pop_base = dq_head; chk_en = 1;
        @(posedge Clk); #1 start_v[idx] = 1'b1;
        @(posedge Clk); #1 start_v[idx] = 1'b0;
        @(negedge Clk);
        chk("lat_valid_cyc1", valid_o[idx], 0);
        chk("busy_init", busy_o[idx], 1);
        @(negedge Clk);
        chk("lat_valid_cyc2", valid_o[idx], 1);
        chk("done_cleared", done_o[idx], 0);
        chk("error_cleared", err_o[idx], 0);
    endtask

    task automatic run_end(input int idx);
        int n;
        n = 0;
        while (!(done_o[idx] || err_o[idx]) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("finish_in_budget", int'(n < 200), 1);
        chk("done", done_o[idx], int'(exp_done));
        chk("error", err_o[idx], int'(!exp_done));
        chk("busy_end", busy_o[idx], 0);
        chk("pop_count", dq_head - pop_base, exp_pops);
        chk("final_x", x_o[idx], exp_fx);
        chk("final_y", y_o[idx], exp_fy);
`ifdef PATH_STEP_COUNT_EN
        chk("steps", steps_o[idx], exp_pops);
`endif
        repeat (3) @(negedge Clk);
        chk("beat_count", beat_i, exp_n);
        chk_en = 0;
    endtask

    initial begin
        int n;
        Rst_n = 1'b1; start_v = '0; out_ready = 1'b1; sel = 0; chk_en = 0;
        checks = 0; errors = 0; dq_head = 0; dq_tail = 0; beat_i = 0; pop_base = 0;
        fork
            forever begin
                @(posedge Clk);
                if (pop_o[sel] && !deque_empty) dq_head <= dq_head + 1;
            end
            begin : compare
                bit prev_stall;
                int px, py, pd;
                prev_stall = 0; px = 0; py = 0; pd = 0;
                forever begin
                    @(negedge Clk);
                    if (chk_en) begin
                        if (pop_o[sel]) chk("pop_nonempty", deque_empty, 0);
                        if (prev_stall) begin
                            chk("hold_valid", valid_o[sel], 1);
                            chk("hold_x", x_o[sel], px);
                            chk("hold_y", y_o[sel], py);
                            chk("hold_dir", dir_o[sel], pd);
                        end
                        if (valid_o[sel]) begin
                            if (beat_i < exp_n) begin
                                chk("beat_x", x_o[sel], exp_x[beat_i]);
                                chk("beat_y", y_o[sel], exp_y[beat_i]);
                                chk("beat_dir", dir_o[sel], exp_d[beat_i]);
                            end else begin
                                chk("extra_beat", beat_i, exp_n - 1);
                            end
                            if (out_ready) beat_i++;
                        end
                        prev_stall = valid_o[sel] && !out_ready;
                        px = x_o[sel]; py = y_o[sel]; pd = dir_o[sel];
                    end else begin
                        prev_stall = 0;
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        #2 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", valid_o[i], 0);
            chk("rst_busy", busy_o[i], 0);
            chk("rst_done", done_o[i], 0);
            chk("rst_x", x_o[i], 0);
        end
        @(posedge Clk); #1 Rst_n = 1'b1;

        // Empty deque, goal (0,0)
        run_begin(0);
        run_end(0);
        chk("t1_model_beats", exp_n, 1);

        // Path up,right,right to (2,1)
        push(2'b00); push(2'b01); push(2'b01);
        run_begin(1);
        run_end(1);
        chk("t2_model_beats", exp_n, 4);
        chk("t2_model_x2", exp_x[2], 1);

        // Same path, sink stalls on beat (0,1)
        push(2'b00); push(2'b01); push(2'b01);
        run_begin(1);
        n = 0;
        do begin @(negedge Clk); n++; end while (!pop_o[1] && n < 20);
        chk("t3_first_pop", pop_o[1], 1);
        @(posedge Clk); #1 out_ready = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            chk("stall_valid", valid_o[1], 1);
            chk("stall_x", x_o[1], 0);
            chk("stall_y", y_o[1], 1);
            chk("stall_pop", pop_o[1], 0);
        end
        @(posedge Clk); #1 out_ready = 1'b1;
        run_end(1);
        chk("t3_done", done_o[1], 1);

        // Left from column 0
        push(2'b10);
        run_begin(2);
        run_end(2);
        chk("t4_model_pops", exp_pops, 1);
        chk("t4_x", x_o[2], 0);

        // Single up step, goal (15,15) unreached
        push(2'b00);
        run_begin(2);
        run_end(2);
        chk("t5_model_beats", exp_n, 2);
        chk("t5_done", done_o[2], 0);

        // Reset mid-replay, then restart on the remaining entry
        push(2'b00); push(2'b00); push(2'b00);
        run_begin(3);
        n = 0;
        while ((dq_head - pop_base) < 2 && n < 50) begin @(negedge Clk); n++; end
        chk_en = 0;
        Rst_n = 1'b0;
        #1;
        chk("mrst_valid", valid_o[3], 0);
        chk("mrst_pop", pop_o[3], 0);
        chk("mrst_x", x_o[3], 0);
        chk("mrst_y", y_o[3], 0);
        chk("mrst_dir", dir_o[3], 0);
        chk("mrst_busy", busy_o[3], 0);
        chk("mrst_done", done_o[3], 0);
        chk("mrst_error", err_o[3], 0);
        @(posedge Clk); #1 Rst_n = 1'b1;
        chk("mrst_remaining", dq_tail - dq_head, 1);
        run_begin(3);
        run_end(3);
        chk("t6_model_beats", exp_n, 2);
        chk("t6_done", done_o[3], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
